// File: rtl/stack_mem_loader.sv
// stack_mem_loader: unified program/data memory for the stack-machine core.
// - Combinational read port feeding the core's data_in.
// - Decodes the core's two-cycle store (0xFF marker, then address/data) into writes.
// - After reset, loads a byte-serial program image while holding the core in
//   reset, then releases it.
// Optional feature macro: STACK_MEM_WRITE_PROTECT_EN
//   When defined, core stores to words 0..PROT_LIMIT-1 are suppressed.
module stack_mem_loader #(
   parameter int         DEPTH      = 32,
   parameter logic [7:0] FILL       = 8'hFF,
   parameter int         PROT_LIMIT = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_reset,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   input  logic       load_last,
   output logic       load_ready,
   input  logic       reload,
   output logic       running
);

   localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]       DEPTH_LIM = 9'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   // Parameter legality is checked at elaboration so a bad DEPTH or
   // PROT_LIMIT cannot silently produce a truncated address decode.
   if (DEPTH < 2 || DEPTH > 256 || PROT_LIMIT < 0 || PROT_LIMIT > 256) begin : g_bad_param
      $error("stack_mem_loader: DEPTH must be 2..256 and PROT_LIMIT 0..256");
   end

   typedef enum logic {LOAD, RUN}   top_state_t;
   typedef enum logic {IDLE, ARMED} wr_state_t;

   top_state_t       state, state_next;
   wr_state_t        wr_state, wr_next;
   logic [PTR_W-1:0] load_ptr, ptr_next;
   logic [7:0]       mem [DEPTH];

   logic             load_accept;
   logic             load_done;
   logic             addr_in_range;
   logic             addr_writable;
   logic             store_en;

   // Address decode uses the full 8-bit address so out-of-range never aliases.
   always_comb begin
      addr_in_range = ({1'b0, cpu_addr} < DEPTH_LIM);
`ifdef STACK_MEM_WRITE_PROTECT_EN
      addr_writable = addr_in_range && !({1'b0, cpu_addr} < 9'(PROT_LIMIT));
`else
      addr_writable = addr_in_range;
`endif
   end

   // Loader handshake and store qualification; reload drops an ARMED store.
   always_comb begin
      load_accept = (state == LOAD) && load_valid;
      load_done   = load_accept && (load_last || (load_ptr == LAST_PTR));
      store_en    = (state == RUN) && (wr_state == ARMED) && !reload && addr_writable;
   end

   // Zero-latency read path, valid in every state.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      cpu_rdata = 8'h00;
      if (addr_in_range) begin
         cpu_rdata = mem[cpu_addr[PTR_W-1:0]];
      end
   end

   // Next-state and outputs for the top FSM, store decoder and load pointer.
   always_comb begin
      state_next = state;
      wr_next    = IDLE;
      ptr_next   = load_ptr;
      cpu_reset  = 1'b1;
      load_ready = 1'b1;
      running    = 1'b0;
      unique case (state)
         LOAD: begin
            if (load_accept) begin
               if (load_done) begin
                  state_next = RUN;
                  ptr_next   = '0;
               end else begin
                  ptr_next = load_ptr + 1'b1;
               end
            end
         end
         RUN: begin
            cpu_reset  = 1'b0;
            load_ready = 1'b0;
            running    = 1'b1;
            if (reload) begin
               state_next = LOAD;
               ptr_next   = '0;
            end else if (wr_state == IDLE && cpu_wdata == 8'hFF) begin
               wr_next = ARMED;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // State registers for the top FSM, store decoder and load pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= LOAD;
         wr_state <= IDLE;
         load_ptr <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state    <= state_next;
         wr_state <= wr_next;
         load_ptr <= ptr_next;
      end
   end

   // Memory array: loader writes in LOAD, decoded core stores in RUN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the memory is deliberately reset so unloaded words read as the NUL opcode.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= FILL;
         end
      end else if (load_accept) begin
         mem[load_ptr] <= load_data;
      end else if (store_en) begin
         mem[cpu_addr[PTR_W-1:0]] <= cpu_wdata;
      end
   end

endmodule

// File: tb/tb_stack_mem_loader.sv
// Directed testbench for stack_mem_loader (DEPTH=32, FILL=FF, PROT_LIMIT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled later in
// the same cycle, away from the active edge.
module tb_stack_mem_loader;

   logic       clock;
   logic       reset;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_reset;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       reload;
   logic       running;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef STACK_MEM_WRITE_PROTECT_EN
   localparam logic [7:0] EXP_PROT3 = 8'hFF;
`else
   localparam logic [7:0] EXP_PROT3 = 8'hC3;
`endif

   stack_mem_loader #(.DEPTH(32), .FILL(8'hFF), .PROT_LIMIT(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_reset  (cpu_reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .reload     (reload),
      .running    (running)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
      cpu_wdata = 8'h00;
      cpu_addr  = a;
      #1;
      check(tag, cpu_rdata, exp);
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
   endtask

   task automatic cpu_cycle(input logic [7:0] a, input logic [7:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      cpu_addr   = 8'h00;
      cpu_wdata  = 8'h00;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      reload     = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("por_cpu_reset", {7'd0, cpu_reset}, 8'd1);
      check("por_running", {7'd0, running}, 8'd0);

      // 1. Get to RUN, then assert reset mid-cycle: outputs change with no edge.
      load_byte(8'h08, 1'b1);
      check("t1_run_before_reset", {7'd0, running}, 8'd1);
      reset = 1'b1;
      #1;
      check("t1_async_cpu_reset", {7'd0, cpu_reset}, 8'd1);
      check("t1_async_load_ready", {7'd0, load_ready}, 8'd1);
      check("t1_async_running", {7'd0, running}, 8'd0);
      rd(8'd0,  8'hFF, "t1_refill_addr0");
      rd(8'd5,  8'hFF, "t1_read_addr5");
      rd(8'd40, 8'h00, "t1_read_addr40");
      tick();
      reset = 1'b0;

      // 2. Three-byte image with a bubble between bytes 1 and 2.
      load_byte(8'h08, 1'b0);
      check("t2_still_load", {7'd0, load_ready}, 8'd1);
      tick();
      load_byte(8'h07, 1'b0);
      check("t2_not_running", {7'd0, running}, 8'd0);
      load_byte(8'h0E, 1'b1);
      check("t2_running", {7'd0, running}, 8'd1);
      check("t2_cpu_reset", {7'd0, cpu_reset}, 8'd0);
      check("t2_load_ready", {7'd0, load_ready}, 8'd0);
      rd(8'd0, 8'h08, "t2_mem0");
      rd(8'd1, 8'h07, "t2_mem1");
      rd(8'd2, 8'h0E, "t2_mem2");
      rd(8'd3, 8'hFF, "t2_mem3");

      // 3. Store: marker then data; visible the cycle after the write edge.
      cpu_cycle(8'h01, 8'hFF);
      cpu_addr  = 8'h14;
      cpu_wdata = 8'h2A;
      #1;
      check("t3_before_write", cpu_rdata, 8'hFF);
      tick();
      cpu_wdata = 8'h00;
      #1;
      check("t3_after_write", cpu_rdata, 8'h2A);
      rd(8'd1, 8'h07, "t3_marker_no_write");
      // Marker then FF writes FF; ARMED does not re-arm, so 2A next is ignored.
      cpu_cycle(8'h09, 8'hFF);
      cpu_cycle(8'h02, 8'hFF);
      cpu_cycle(8'h03, 8'h2A);
      rd(8'd2, 8'hFF, "t3_ff_written");
      rd(8'd3, 8'hFF, "t3_no_rearm");

      // 4. Out-of-range store is dropped and does not alias.
      cpu_cycle(8'h09, 8'hFF);
      cpu_cycle(8'hF0, 8'h55);
      rd(8'hF0, 8'h00, "t4_oor_read");
      rd(8'd16, 8'hFF, "t4_no_alias");
      rd(8'd20, 8'h2A, "t4_mem20_kept");
      rd(8'd0,  8'h08, "t4_mem0_kept");

      // 5a. reload coincident with the ARMED cycle drops the store.
      cpu_cycle(8'h09, 8'hFF);
      cpu_addr  = 8'h04;
      cpu_wdata = 8'h77;
      reload    = 1'b1;
      tick();
      reload    = 1'b0;
      cpu_wdata = 8'h00;
      check("t5_reload_cpu_reset", {7'd0, cpu_reset}, 8'd1);
      check("t5_reload_running", {7'd0, running}, 8'd0);
      rd(8'd4,  8'hFF, "t5_store_dropped");
      rd(8'd20, 8'h2A, "t5_mem_intact");

      // 4b. Full 32-byte image without load_last auto-exits; byte 33 ignored.
      for (int i = 0; i < 32; i++) begin
         load_byte(8'(8'h40 + i), 1'b0);
         if (i == 30) check("t4_byte31_load", {7'd0, running}, 8'd0);
      end
      check("t4_full_running", {7'd0, running}, 8'd1);
      load_valid = 1'b1;
      load_data  = 8'h99;
      tick();
      load_valid = 1'b0;
      check("t4_extra_ignored_run", {7'd0, running}, 8'd1);
      rd(8'd0,  8'h40, "t4_full_mem0");
      rd(8'd20, 8'h54, "t4_full_mem20");
      rd(8'd31, 8'h5F, "t4_full_mem31");

      // 5b. Async reset during LOAD after two bytes refills memory and pointer.
      reload = 1'b1;
      tick();
      reload = 1'b0;
      load_byte(8'h11, 1'b0);
      load_byte(8'h22, 1'b0);
      reset = 1'b1;
      #1;
      rd(8'd0,  8'hFF, "t5_rst_mem0");
      rd(8'd1,  8'hFF, "t5_rst_mem1");
      rd(8'd31, 8'hFF, "t5_rst_mem31");
      tick();
      reset = 1'b0;
      load_byte(8'h33, 1'b1);
      check("t5_rst_reload_run", {7'd0, running}, 8'd1);
      rd(8'd0, 8'h33, "t5_ptr_restart");
      rd(8'd1, 8'hFF, "t5_short_image");

      // 6. Write-protect region (expectation depends on the build).
      cpu_cycle(8'h09, 8'hFF);
      cpu_cycle(8'h03, 8'hC3);
      rd(8'd3, EXP_PROT3, "t6_store_addr3");
      cpu_cycle(8'h09, 8'hFF);
      cpu_cycle(8'h08, 8'hAA);
      rd(8'd8, 8'hAA, "t6_store_addr8");
      reload = 1'b1;
      tick();
      reload = 1'b0;
      load_byte(8'h01, 1'b0);
      load_byte(8'h02, 1'b0);
      load_byte(8'h03, 1'b0);
      load_byte(8'h04, 1'b1);
      check("t6_loader_run", {7'd0, running}, 8'd1);
      rd(8'd3, 8'h04, "t6_loader_addr3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_mem_loader.md
Name: stack_mem_loader

Overview:
- Unified program/data memory that sits directly downstream of the stack-machine core, on its mem_addr/data_out/data_in bus.
- Serves combinational reads to the core and decodes the core's two-cycle store sequence into memory writes.
- After reset, accepts a byte-serial program image over a valid/ready load port while holding the core in reset, then releases it.

Parameters:
- DEPTH, 32, number of 8-bit memory words; legal range 2..256.
- FILL, 8'hFF, reset value of every word; low nibble F decodes as the core's NUL opcode.
- PROT_LIMIT, 8, store-protected words 0..PROT_LIMIT-1; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  8  core mem_addr.
- cpu_wdata  in  8  core data_out.
- cpu_rdata  out  8  read data to the core's data_in.
- cpu_reset  out  1  drives the core's reset input.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte.
- load_last  in  1  marks the final byte of the image; qualified by load_valid.
- load_ready  out  1  block can accept a loader byte.
- reload  in  1  single-cycle request to return to LOAD.
- running  out  1  high in RUN.

Behaviour:
- Reset (async):
  - state=LOAD, load_ptr=0, wr_fsm=IDLE, every mem word=FILL.
  - Outputs: cpu_reset=1, load_ready=1, running=0, cpu_rdata=mem[cpu_addr] (FILL).
- Read path:
  - cpu_rdata = mem[cpu_addr] when cpu_addr<DEPTH, else 8'h00.
  - Purely combinational, zero latency, valid in every state.
  - The core samples data_in in the same cycle it drives the address.
- Top FSM, states LOAD and RUN:
  - LOAD: cpu_reset=1, load_ready=1, running=0. Store decoding is disabled; wr_fsm is held in IDLE.
  - LOAD handshake: a byte is accepted on a rising edge with load_valid&&load_ready. It writes mem[load_ptr]=load_data and load_ptr+=1.
  - LOAD exit: if the accepted byte has load_last=1, or load_ptr==DEPTH-1, next state is RUN and load_ptr=0.
  - Image size: excess image bytes never wrap the pointer. An image shorter than DEPTH leaves the remaining words at their prior value.
  - RUN: cpu_reset=0, load_ready=0, running=1, and load_valid is ignored. Because the core's reset is synchronous, the core begins FETCH at pc=0 on the first RUN cycle.
  - reload: when reload=1 in RUN, next state is LOAD, load_ptr=0, wr_fsm=IDLE. Memory is not refilled. An in-flight ARMED store is dropped.
  - reload in LOAD has no effect.
- Store decode FSM (wr_fsm), active only in RUN:
  - IDLE: if cpu_wdata==8'hFF, go to ARMED. The core emits this marker while fetching the store operand.
  - ARMED: unconditionally write mem[cpu_addr]=cpu_wdata on this edge, then return to IDLE. The write is suppressed if cpu_addr>=DEPTH.
  - ARMED never re-arms in the same cycle. A sequence of 0xFF,0xFF,0xFF,0xFF therefore gives: ARMED, write 0xFF, ARMED, write 0xFF.
  - Write latency: a store is visible on cpu_rdata the cycle after the write edge.
- Simultaneous events:
  - Top-level reload has priority over a pending ARMED write; the write is dropped.
  - Async reset overrides everything, mid-load or mid-store.
- Width rules:
  - load_ptr width is clog2(DEPTH) bits.
  - Address compare uses the full 8-bit cpu_addr, so no aliasing occurs.

Optional Feature:
- Macro: STACK_MEM_WRITE_PROTECT_EN.
- Defined: ARMED-cycle writes with cpu_addr<PROT_LIMIT are suppressed (program region is read-only to the core). wr_fsm still returns to IDLE. Loader writes are unaffected.
- Undefined: all in-range addresses are writable by the core, and PROT_LIMIT is ignored.

Test Plan:
1. Reset then read:
   - Stimulus: assert reset mid-cycle.
   - Required: cpu_reset=1, load_ready=1 immediately, without waiting for a clock edge. cpu_rdata=8'hFF for cpu_addr=5; cpu_rdata=8'h00 for cpu_addr=40 (DEPTH=32).
2. Load image:
   - Stimulus: load bytes 8'h08,8'h07,8'h0E with load_last on the third byte, inserting a load_valid=0 bubble between bytes 1 and 2.
   - Required: mem[0..2]=08,07,0E and mem[3]=FF. running=1 and cpu_reset=0 on the cycle after the third accept.
3. Store sequence:
   - Stimulus: in RUN, cpu_wdata=FF, cpu_addr=1; next cycle cpu_wdata=8'h2A, cpu_addr=8'h14.
   - Required: mem[20]=2A, readable on the following cycle. Separately, a lone marker followed by cpu_wdata=FF writes FF.
4. Overflow and full image:
   - Stimulus: a store to cpu_addr=8'hF0.
   - Required: no write; no other word changes.
   - Stimulus: a 32-byte load without load_last.
   - Required: auto-transition to RUN after byte 32; a 33rd load_valid is ignored.
5. reload and reset races:
   - Stimulus: reload coincident with the ARMED cycle.
   - Required: store dropped, state=LOAD, cpu_reset=1, memory otherwise intact.
   - Stimulus: async reset during LOAD after 2 bytes.
   - Required: load_ptr=0 and all words=FF.
6. Write-protect build (STACK_MEM_WRITE_PROTECT_EN defined, PROT_LIMIT=8):
   - Stimulus: core store to addr 3.
   - Required: mem[3] unchanged.
   - Stimulus: core store to addr 8.
   - Required: write succeeds.
   - Stimulus: loader write to addr 3.
   - Required: write succeeds.
